// File: rtl/hilo_muldiv_pkg.sv
// Shared op and state encodings for the HI/LO multiply/divide unit.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic is_signed_op(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with final sign fix.
module hilo_iter_core
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             res_valid,
    output logic             res_div_zero,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e state, state_nx;
    op_e op_in, op_q;
    logic neg_a, neg_b, b_zero, sgn_in;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, abs_a, abs_b;
    logic [CW-1:0] count;

    logic [WIDTH:0] add_sum, trial;
    logic div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign op_in  = op_e'(op);
    assign sgn_in = is_signed_op(op_in);
    assign abs_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
    assign abs_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (count == LAST) state_nx = S_FIX;
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Multiply: acc_lo holds the multiplier and shifts right as product bits enter from acc_hi.
    // Divide: acc_lo holds the dividend and shifts left as quotient bits enter; acc_hi is the remainder.
    assign add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign trial   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge  = (trial >= {1'b0, opnd});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_MULT;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            b_zero <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            count  <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    op_q   <= op_in;
                    neg_a  <= sgn_in & a[WIDTH-1];
                    neg_b  <= sgn_in & b[WIDTH-1];
                    b_zero <= (b == '0);
                    acc_hi <= '0;
                    acc_lo <= abs_a;
                    opnd   <= abs_b;
                    count  <= '0;
                end
                S_RUN: begin
                    count <= count + 1'b1;
                    if (is_div_op(op_q)) begin
                        acc_hi <= div_ge ? WIDTH'(trial - {1'b0, opnd}) : trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= add_sum[WIDTH:1];
                        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Divide-by-zero naturally leaves remainder = |a|; the dividend sign fix restores a as given.
    always_comb begin
        prod   = {acc_hi, acc_lo};
        quo    = acc_lo;
        rem    = acc_hi;
        res_hi = '0;
        res_lo = '0;
        if (is_div_op(op_q)) begin
            if (op_q == OP_DIV && (neg_a ^ neg_b)) quo = -quo;
            if (op_q == OP_DIV && neg_a)           rem = -rem;
            if (b_zero)                            quo = '1;
            res_hi = rem;
            res_lo = quo;
        end else begin
            if (op_q == OP_MULT && (neg_a ^ neg_b)) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    assign busy         = (state != S_IDLE);
    assign res_valid    = (state == S_FIX);
    assign res_div_zero = is_div_op(op_q) & b_zero;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with direct writes, gated reads and an iterative mul/div engine.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter bit          OUT_TRISTATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hi_rd,
    input  logic             lo_rd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    logic [WIDTH-1:0] hi_q, lo_q, res_hi, res_lo;
    logic res_valid, res_div_zero;

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_div_zero (res_div_zero),
        .res_hi       (res_hi),
        .res_lo       (res_lo)
    );

    // Commit outranks a same-edge MTHI/MTLO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q     <= '0;
            lo_q     <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= res_valid;
            if (res_valid)  hi_q <= res_hi;
            else if (hi_we) hi_q <= wdata;
            if (res_valid)  lo_q <= res_lo;
            else if (lo_we) lo_q <= wdata;
            if (start && !busy) div_zero <= 1'b0;
            else if (res_valid) div_zero <= res_div_zero;
        end
    end

    assign hi_out = hi_rd ? hi_q : (OUT_TRISTATE ? {WIDTH{1'bz}} : '0);
    assign lo_out = lo_rd ? lo_q : (OUT_TRISTATE ? {WIDTH{1'bz}} : '0);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed checks of hilo_muldiv against an arithmetic reference model.
module tb_hilo_muldiv;

    localparam int unsigned W = 32;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst, start, hi_we, lo_we, hi_rd, lo_rd;
    logic [1:0] op;
    logic [W-1:0] a, b, wdata;
    logic [W-1:0] hi_out, lo_out;
    logic busy, done, div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.WIDTH(W), .OUT_TRISTATE(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi_rd(hi_rd), .lo_rd(lo_rd),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
    );

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy;
        int q, r;
        case (o)
            2'd0: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            2'd1: return {32'h0, x} * {32'h0, y};
            2'd2: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
                return {r, q};
            end
            default: begin
                if (y == 32'h0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output bit busy_ok,
                          output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        hi_rd = 1'b1;
        lo_rd = 1'b1;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        h  = hi_out;
        l  = lo_out;
        dz = div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        n_checks++;
        if (hi_out !== '0 || lo_out !== '0 || busy !== 1'b0 || done !== 1'b0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, required all zero", hi_out, lo_out, busy, done, div_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit seen_done;
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_0001;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        n_checks++;
        if (hi_out !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL preload_hi: got %h, required a5a50001", hi_out);
        end
        start = 1'b1; op = 2'd1; a = '1; b = '1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (hi_out !== '0 || lo_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: hi=%h lo=%h busy=%b done=%b, required all zero", hi_out, lo_out, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (W + 5) begin
            @(negedge clk);
            if (done || busy || hi_out !== '0) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL reset_abort: aborted op still ran or committed (hi=%h), required no activity", hi_out);
        end
    endtask

    task automatic test_directed();
        logic [1:0]   vo [6] = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd2};
        logic [W-1:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h8000_0000, 32'h7, 32'hFFFF_FFF9};
        logic [W-1:0] vb [6] = '{32'hFFFF_FFFF, 32'h5, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [W-1:0] eh [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h7, 32'hFFFF_FFF9};
        logic [W-1:0] el [6] = '{32'h1, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic         ez [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat; bit bok; logic [W-1:0] h, l; logic dz;
        for (int i = 0; i < 6; i++) begin
            run_op(vo[i], va[i], vb[i], lat, bok, h, l, dz);
            n_checks++;
            if (lat != LAT || !bok) begin
                n_fail++;
                $display("FAIL dir%0d_latency: lat=%0d busy_ok=%0b, required lat=%0d busy_ok=1", i, lat, bok, LAT);
            end
            n_checks++;
            if (h !== eh[i] || l !== el[i] || dz !== ez[i]) begin
                n_fail++;
                $display("FAIL dir%0d_result: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b", i, h, l, dz, eh[i], el[i], ez[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] o; logic [W-1:0] x, y; logic [2*W-1:0] exp;
        int lat; bit bok; logic [W-1:0] h, l; logic dz, ezr;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = '0;
                1: begin x = 32'h8000_0000; y = '1; end
                2: begin x = 32'($urandom_range(0, 100)); y = 32'($urandom_range(1, 9)); end
                3: y = 32'($urandom_range(0, 15)) - 32'd8;
                default: ;
            endcase
            exp = model(o, x, y);
            ezr = o[1] && (y == '0);
            run_op(o, x, y, lat, bok, h, l, dz);
            n_checks++;
            if (lat != LAT || !bok || h !== exp[2*W-1:W] || l !== exp[W-1:0] || dz !== ezr) begin
                n_fail++;
                $display("FAIL rand%0d op=%0d a=%h b=%h: lat=%0d busy_ok=%0b hi=%h lo=%h dz=%b, required lat=%0d hi=%h lo=%h dz=%b",
                         i, o, x, y, lat, bok, h, l, dz, LAT, exp[2*W-1:W], exp[W-1:0], ezr);
            end
        end
    endtask

    task automatic test_div_zero_clear();
        int lat; bit bok; logic [W-1:0] h, l; logic dz; int n;
        run_op(2'd3, 32'h7, 32'h0, lat, bok, h, l, dz);
        n_checks++;
        if (dz !== 1'b1) begin
            n_fail++;
            $display("FAIL div_zero_set: got %b, required 1", dz);
        end
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL div_zero_clear: got %b, required 0", div_zero);
        end
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (!done || lo_out !== 32'd12 || hi_out !== '0 || div_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL after_clear_result: done=%b hi=%h lo=%h dz=%b, required done=1 hi=0 lo=c dz=0", done, hi_out, lo_out, div_zero);
        end
    endtask

    task automatic test_collisions();
        bit hold_ok = 1'b1;
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = '1; b = '1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            start = (e == 3);
            if (e == 3) begin op = 2'd2; a = 32'd5; b = 32'd1; end
            hi_we = (e == 10);
            lo_we = (e == LAT);
            wdata = (e == LAT) ? 32'h5555_5555 : 32'h1234;
            @(negedge clk);
            if (e >= 10 && e < LAT && (hi_out !== 32'h1234 || done)) hold_ok = 1'b0;
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_checks++;
        if (!hold_ok) begin
            n_fail++;
            $display("FAIL mthi_while_busy: hi did not hold 00001234 until commit (now %h)", hi_out);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || hi_out !== 32'hFFFF_FFFE || lo_out !== 32'h1) begin
            n_fail++;
            $display("FAIL collision_commit: done=%b busy=%b hi=%h lo=%h, required done=1 busy=0 hi=fffffffe lo=00000001",
                     done, busy, hi_out, lo_out);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_while_busy_ignored: busy=%b done=%b after commit, required 0 0", busy, done);
        end
    endtask

    task automatic test_start_with_write();
        int n;
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        n_checks++;
        if (hi_out !== 32'hDEAD_BEEF || lo_out !== 32'hDEAD_BEEF || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_with_write: hi=%h lo=%h busy=%b, required deadbeef deadbeef 1", hi_out, lo_out, busy);
        end
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        n_checks++;
        if (hi_out !== '0 || lo_out !== 32'd42) begin
            n_fail++;
            $display("FAIL start_with_write_commit: hi=%h lo=%h, required 0 2a", hi_out, lo_out);
        end
    endtask

    task automatic test_mt_and_enable();
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b0; wdata = 32'h1111_1111;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h2222_2222;
        @(negedge clk);
        lo_we = 1'b0;
        n_checks++;
        if (hi_out !== 32'h1111_1111 || lo_out !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h, required 11111111 22222222", hi_out, lo_out);
        end
        hi_we = 1'b1; wdata = 32'h3333_3333;
        #1;
        n_checks++;
        if (hi_out !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL no_bypass: hi=%h before edge, required 11111111", hi_out);
        end
        @(negedge clk);
        hi_we = 1'b0;
        n_checks++;
        if (hi_out !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL mthi_after_edge: hi=%h, required 33333333", hi_out);
        end
        hi_rd = 1'b0; lo_rd = 1'b0;
        #1;
        n_checks++;
        if (hi_out !== '0 || lo_out !== '0) begin
            n_fail++;
            $display("FAIL read_disable: hi=%h lo=%h, required 0 0", hi_out, lo_out);
        end
        hi_rd = 1'b1; lo_rd = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; hi_rd = 1'b1; lo_rd = 1'b1;
        test_reset();
        test_reset_mid_run();
        test_directed();
        test_random();
        test_div_zero_clear();
        test_collisions();
        test_start_with_write();
        test_mt_and_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
